// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and counter sizing for the PISO serializer.
package piso_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable down-counter that stops at zero and flags terminal count.
module piso_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_count <= '0;
    else if (load_i) r_count <= load_val_i;
    else if (en_i && r_count != '0) r_count <= r_count - 1'b1;
  end
  assign tc_o = (r_count == '0);
endmodule

// File: rtl/piso_stream_serializer.sv
// piso_stream_serializer: strobe-paced PISO with valid/ready load and gapless back-to-back frames.
module piso_stream_serializer
  import piso_pkg::*;
#(
  parameter int   N          = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         shift_en_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] data_i,
  output logic         serial_o,
  output logic         serial_valid_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_sreg, w_sreg_nxt;
  logic         r_serial, r_done;
  logic         w_shift, w_last, w_tc, w_accept, w_head_nxt;
  assign w_shift  = (r_state == SHIFT) && shift_en_i;
  assign w_last   = w_shift && w_tc;
  assign ready_o  = (r_state == IDLE) || w_last;
  assign w_accept = valid_i && ready_o;
  piso_bit_counter #(.W(CW)) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (w_accept),
    .load_val_i (LAST_IDX),
    .en_i       (w_shift),
    .tc_o       (w_tc)
  );
  // The last-bit shift also runs, so an idle register drains to all zeros.
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    if (w_shift) w_sreg_nxt = MSB_FIRST ? {r_sreg[N-2:0], 1'b0} : {1'b0, r_sreg[N-1:1]};
    if (w_accept) begin
      w_sreg_nxt  = data_i;
      w_state_nxt = SHIFT;
    end else if (w_last) begin
      w_state_nxt = IDLE;
    end
  end
  assign w_head_nxt = MSB_FIRST ? w_sreg_nxt[N-1] : w_sreg_nxt[0];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sreg   <= '0;
      r_serial <= IDLE_LEVEL;
      r_done   <= 1'b0;
    end else begin
      r_sreg   <= w_sreg_nxt;
      r_serial <= (w_state_nxt == SHIFT) ? w_head_nxt : IDLE_LEVEL;
      r_done   <= w_last;
    end
  end
  assign serial_o       = r_serial;
  assign serial_valid_o = (r_state == SHIFT);
  assign busy_o         = (r_state == SHIFT);
  assign done_o         = r_done;
endmodule

// File: tb/tb_piso_stream_serializer.sv
// tb_piso_stream_serializer: MSB- and LSB-first instances against a queue-based frame model.
module tb_piso_stream_serializer;
  localparam int N = 8;
  logic         clk_i = 1'b0, rst_ni = 1'b0, shift_en_i = 1'b0, valid_i = 1'b0;
  logic [N-1:0] data_i = '0;
  logic         ready_m, serial_m, sv_m, busy_m, done_m;
  logic         ready_l, serial_l, sv_l, busy_l, done_l;
  int           checks = 0, errors = 0, cyc = 0, se_mode = 0;
  bit           act = 0, done_exp = 0, acc = 0;
  bit           qm[$], ql[$];
  piso_stream_serializer #(.N(N), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk_i(clk_i), .rst_ni(rst_ni), .shift_en_i(shift_en_i), .valid_i(valid_i),
    .ready_o(ready_m), .data_i(data_i), .serial_o(serial_m),
    .serial_valid_o(sv_m), .busy_o(busy_m), .done_o(done_m)
  );
  piso_stream_serializer #(.N(N), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
    .clk_i(clk_i), .rst_ni(rst_ni), .shift_en_i(shift_en_i), .valid_i(valid_i),
    .ready_o(ready_l), .data_i(data_i), .serial_o(serial_l),
    .serial_valid_o(sv_l), .busy_o(busy_l), .done_o(done_l)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic check_outputs();
    check("serial_m", serial_m, act ? 32'(qm[0]) : 32'd0);
    check("serial_l", serial_l, act ? 32'(ql[0]) : 32'd1);
    check("valid_m", sv_m, act);
    check("busy_m", busy_m, act);
    check("valid_l", sv_l, act);
    check("busy_l", busy_l, act);
    check("done_m", done_m, done_exp);
    check("done_l", done_l, done_exp);
  endtask
  // A frame is a queue of bits in send order; the head is what the line shows.
  task automatic step();
    bit rdy;
    @(negedge clk_i);
    check_outputs();
    rdy = !act || (qm.size() == 1 && shift_en_i);
    if (rst_ni) begin
      check("ready_m", ready_m, rdy);
      check("ready_l", ready_l, rdy);
    end
    @(posedge clk_i);
    acc = 0;
    if (rst_ni) begin
      done_exp = act && qm.size() == 1 && shift_en_i;
      if (act && shift_en_i) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (valid_i && rdy) begin
        acc = 1;
        act = 1;
        for (int i = 0; i < N; i++) begin
          qm.push_back(data_i[N-1-i]);
          ql.push_back(data_i[i]);
        end
      end else if (act && qm.size() == 0) begin
        act = 0;
      end
    end else begin
      done_exp = 0;
    end
    cyc++;
    #1;
    shift_en_i = (se_mode == 0) ? 1'b1 : (se_mode == 1) ? (cyc % 4 == 3) : 1'($urandom_range(0, 1));
  endtask
  task automatic send(input logic [N-1:0] d);
    int n;
    valid_i = 1'b1;
    data_i  = d;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", 0, 1);
    valid_i = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    idle(2);
    rst_ni = 1'b1;
    se_mode = 0;
    shift_en_i = 1'b1;
    send(8'hA5);
    idle(10);
    se_mode = 1;
    send(8'h81);
    idle(40);
    se_mode = 0;
    send(8'hFF);
    send(8'h00);
    idle(10);
    se_mode = 2;
    send(8'h5A);
    send(8'hC3);
    idle(30);
    se_mode = 0;
    send(8'hA5);
    idle(2);
    rst_ni = 1'b0;
    act = 0;
    done_exp = 0;
    qm.delete();
    ql.delete();
    #1;
    check_outputs();
    idle(2);
    rst_ni = 1'b1;
    send(8'h3C);
    idle(10);
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) se_mode = $urandom_range(0, 2);
      if (!valid_i && $urandom_range(0, 2) == 0) begin
        valid_i = 1'b1;
        data_i  = N'($urandom);
      end
      step();
      if (acc) begin
        valid_i = 1'($urandom_range(0, 1));
        if (valid_i) data_i = N'($urandom);
      end
    end
    valid_i = 1'b0;
    idle(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
